// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: accepts one command per handshake, pipelines
// address/data phases, and returns one in-order response per command.
`timescale 1ns/1ps

package slave_package;
  typedef enum logic [2:0] {
    BYTE      = 3'b000,
    HALF_WORD = 3'b001,
    WORD      = 3'b010
  } HSIZE_E;
endpackage

module ahb_lite_master
  import slave_package::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  HSIZE_E      cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] xfer_count,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output HSIZE_E      HSIZE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_DATA,
    DATA,
    ERR1,
    CANCEL_RSP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_run;
  logic        r_cancel;
  logic [31:0] r_haddr;
  logic        r_hwrite;
  HSIZE_E      r_hsize;
  logic [31:0] r_awdata;
  logic        r_dwrite;
  logic [31:0] r_dwdata;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [15:0] r_xfer_count;

  logic        w_addr_ph;
  logic        w_data_ph;
  logic        w_data_done;
  logic        w_err_first;
  logic        w_ready_st;
  logic        w_accept;

  assign w_addr_ph   = (r_state == ADDR) || (r_state == ADDR_DATA);
  assign w_data_ph   = (r_state == ADDR_DATA) || (r_state == DATA) || (r_state == ERR1);
  assign w_data_done = w_data_ph && HREADY;
  assign w_err_first = ((r_state == ADDR_DATA) || (r_state == DATA)) && HRESP && !HREADY;
  assign w_accept    = cmd_valid && cmd_ready;

  // r_run keeps cmd_ready low until the first clock edge after reset release.
  assign cmd_ready = r_run && w_ready_st;

  always_comb begin
    w_ready_st = 1'b0;
    case (r_state)
      IDLE, CANCEL_RSP: w_ready_st = 1'b1;
      ADDR, ADDR_DATA:  w_ready_st = HREADY && !HRESP;
      DATA:             w_ready_st = !HRESP;
      default:          w_ready_st = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, CANCEL_RSP: w_next = w_accept ? ADDR : IDLE;
      ADDR: begin
        if (HREADY) w_next = w_accept ? ADDR_DATA : DATA;
      end
      ADDR_DATA: begin
        if (HREADY)     w_next = w_accept ? ADDR_DATA : DATA;
        else if (HRESP) w_next = ERR1;
      end
      DATA: begin
        if (HREADY)     w_next = w_accept ? ADDR : IDLE;
        else if (HRESP) w_next = ERR1;
        else if (w_accept) w_next = ADDR_DATA;
      end
      ERR1: begin
        if (HREADY) w_next = r_cancel ? CANCEL_RSP : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= IDLE;
      r_run    <= 1'b0;
      r_cancel <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      // A pending address phase exists only if the error hit in ADDR_DATA.
      if (w_err_first) r_cancel <= (r_state == ADDR_DATA);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= WORD;
      r_awdata <= '0;
    end else if (w_accept) begin
      r_haddr  <= cmd_addr;
      r_hwrite <= cmd_write;
      r_hsize  <= cmd_size;
      r_awdata <= cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dwrite <= 1'b0;
      r_dwdata <= '0;
    end else if (w_addr_ph && HREADY) begin
      r_dwrite <= r_hwrite;
      r_dwdata <= r_awdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_xfer_count <= '0;
    end else begin
      r_rsp_valid <= w_data_done || (r_state == CANCEL_RSP);
      r_rsp_err   <= w_data_done ? HRESP : (r_state == CANCEL_RSP);
      r_rsp_rdata <= (w_data_done && !r_dwrite) ? HRDATA : '0;
      if (w_data_done) r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign HTRANS     = w_addr_ph ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR      = w_addr_ph ? r_haddr : '0;
  assign HWRITE     = w_addr_ph && r_hwrite;
  assign HSIZE      = w_addr_ph ? r_hsize : WORD;
  assign HWDATA     = (w_data_ph && r_dwrite) ? r_dwdata : '0;
  assign HBURST     = 3'b000;
  assign HPROT      = 4'b0011;
  assign HMASTLOCK  = 1'b0;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;
  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Table-driven bench for ahb_lite_master: per-cycle vectors plus hand-written
// reset-during-transfer and counter-wrap sequences.
`timescale 1ns/1ps

module tb_ahb_lite_master;
  import slave_package::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  HSIZE_E      cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] xfer_count;
  logic [31:0] HADDR;
  logic        HWRITE;
  HSIZE_E      HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .xfer_count(xfer_count),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        rdy;
    logic        resp;
    logic [31:0] rd;
    logic        e_rdy;
    logic [1:0]  e_tr;
    logic [31:0] e_ha;
    logic        e_hw;
    logic [2:0]  e_hs;
    logic [31:0] e_wd;
    logic        e_rv;
    logic        e_re;
    logic [31:0] e_rd;
    logic [15:0] e_cnt;
  } vec_t;

  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  ID = 2'b00;
  localparam logic [2:0]  SB = 3'd0;
  localparam logic [2:0]  SH = 3'd1;
  localparam logic [2:0]  SW = 3'd2;
  localparam logic [31:0] Z  = 32'h0;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tv[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_reset(input int idx);
    chk("rst_htrans",    idx, 32'(HTRANS),     32'h0);
    chk("rst_haddr",     idx, HADDR,           32'h0);
    chk("rst_hwrite",    idx, 32'(HWRITE),     32'h0);
    chk("rst_hsize",     idx, 32'(HSIZE),      32'h2);
    chk("rst_hwdata",    idx, HWDATA,          32'h0);
    chk("rst_rsp_valid", idx, 32'(rsp_valid),  32'h0);
    chk("rst_rsp_rdata", idx, rsp_rdata,       32'h0);
    chk("rst_rsp_err",   idx, 32'(rsp_err),    32'h0);
    chk("rst_count",     idx, 32'(xfer_count), 32'h0);
    chk("rst_cmd_ready", idx, 32'(cmd_ready),  32'h0);
  endtask

  task automatic drive(input vec_t r);
    cmd_valid = r.v;
    cmd_write = r.w;
    cmd_addr  = r.a;
    cmd_size  = HSIZE_E'(r.sz);
    cmd_wdata = r.wd;
    HREADY    = r.rdy;
    HRESP     = r.resp;
    HRDATA    = r.rd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = Z; cmd_size = WORD; cmd_wdata = Z;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = Z;

    // single write, zero wait states
    tv.push_back('{1'b1,1'b1,32'h10,SW,32'hDEADBEEF,1'b1,1'b0,Z, 1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd0});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,NS,32'h10,1'b1,SW,Z,1'b0,1'b0,Z,16'd0});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,32'hDEADBEEF,1'b0,1'b0,Z,16'd0});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b1,1'b0,Z,16'd1});
    // halfword read, one address wait and two data waits; garbage cmd_* while idle-valid
    tv.push_back('{1'b1,1'b0,32'h4,SH,Z,1'b1,1'b0,Z,           1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd1});
    tv.push_back('{1'b0,1'b1,32'hFFFFFFF0,SB,32'h12345678,1'b0,1'b0,Z, 1'b0,NS,32'h4,1'b0,SH,Z,1'b0,1'b0,Z,16'd1});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,NS,32'h4,1'b0,SH,Z,1'b0,1'b0,Z,16'd1});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b0,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd1});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b0,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd1});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,32'h0000BA98,    1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd1});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b1,1'b0,32'h0000BA98,16'd2});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd2});
    // four back-to-back writes
    tv.push_back('{1'b1,1'b1,32'h100,SW,32'hFEDCBA98,1'b1,1'b0,Z, 1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd2});
    tv.push_back('{1'b1,1'b1,32'h104,SW,32'h01234567,1'b1,1'b0,Z, 1'b1,NS,32'h100,1'b1,SW,Z,1'b0,1'b0,Z,16'd2});
    tv.push_back('{1'b1,1'b1,32'h108,SW,32'h89ABCDEF,1'b1,1'b0,Z, 1'b1,NS,32'h104,1'b1,SW,32'hFEDCBA98,1'b0,1'b0,Z,16'd2});
    tv.push_back('{1'b1,1'b1,32'h10C,SW,32'h13579BDF,1'b1,1'b0,Z, 1'b1,NS,32'h108,1'b1,SW,32'h01234567,1'b1,1'b0,Z,16'd3});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,NS,32'h10C,1'b1,SW,32'h89ABCDEF,1'b1,1'b0,Z,16'd4});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,32'h13579BDF,1'b1,1'b0,Z,16'd5});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b1,1'b0,Z,16'd6});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd6});
    // write A errors while read B is in its address phase; B is cancelled
    tv.push_back('{1'b1,1'b1,32'h200,SW,32'hAAAA5555,1'b1,1'b0,Z, 1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd6});
    tv.push_back('{1'b1,1'b0,32'h300,SW,Z,1'b1,1'b0,Z,         1'b1,NS,32'h200,1'b1,SW,Z,1'b0,1'b0,Z,16'd6});
    tv.push_back('{1'b1,1'b1,32'h999,SB,32'h55555555,1'b0,1'b1,Z, 1'b0,NS,32'h300,1'b0,SW,32'hAAAA5555,1'b0,1'b0,Z,16'd6});
    tv.push_back('{1'b1,1'b1,32'h999,SB,32'h55555555,1'b1,1'b1,32'hDEADDEAD, 1'b0,ID,Z,1'b0,SW,32'hAAAA5555,1'b0,1'b0,Z,16'd6});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,32'hDEADDEAD,    1'b1,ID,Z,1'b0,SW,Z,1'b1,1'b1,Z,16'd7});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b1,1'b1,Z,16'd7});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd7});
    // single-cycle HRESP=1 with HREADY=1: error completion, pipelined read continues
    tv.push_back('{1'b1,1'b0,32'h400,SW,Z,1'b1,1'b0,Z,         1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd7});
    tv.push_back('{1'b1,1'b0,32'h404,SW,Z,1'b1,1'b0,Z,         1'b1,NS,32'h400,1'b0,SW,Z,1'b0,1'b0,Z,16'd7});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b1,32'h11112222,    1'b0,NS,32'h404,1'b0,SW,Z,1'b0,1'b0,Z,16'd7});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,32'h33334444,    1'b1,ID,Z,1'b0,SW,Z,1'b1,1'b1,32'h11112222,16'd8});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b1,1'b0,32'h33334444,16'd9});
    tv.push_back('{1'b0,1'b0,Z,SW,Z,1'b1,1'b0,Z,               1'b1,ID,Z,1'b0,SW,Z,1'b0,1'b0,Z,16'd9});

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_reset(0);
    chk("hburst",    0, 32'(HBURST),    32'h0);
    chk("hprot",     0, 32'(HPROT),     32'h3);
    chk("hmastlock", 0, 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;
    #1 chk("ready_before_first_edge", 0, 32'(cmd_ready), 32'h0);

    foreach (tv[k]) begin
      @(posedge HCLK);
      #1 drive(tv[k]);
      @(negedge HCLK);
      chk("cmd_ready", k, 32'(cmd_ready),  32'(tv[k].e_rdy));
      chk("htrans",    k, 32'(HTRANS),     32'(tv[k].e_tr));
      chk("haddr",     k, HADDR,           tv[k].e_ha);
      chk("hwrite",    k, 32'(HWRITE),     32'(tv[k].e_hw));
      chk("hsize",     k, 32'(HSIZE),      32'(tv[k].e_hs));
      chk("hwdata",    k, HWDATA,          tv[k].e_wd);
      chk("rsp_valid", k, 32'(rsp_valid),  32'(tv[k].e_rv));
      chk("rsp_err",   k, 32'(rsp_err),    32'(tv[k].e_re));
      chk("rsp_rdata", k, rsp_rdata,       tv[k].e_rd);
      chk("count",     k, 32'(xfer_count), 32'(tv[k].e_cnt));
    end

    // reset asserted while a write sits in a stalled data phase
    @(posedge HCLK);
    #1 begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_size = WORD;
      cmd_wdata = 32'hCAFEF00D; HREADY = 1'b1; HRESP = 1'b0; HRDATA = Z;
    end
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    @(posedge HCLK);
    #1 HREADY = 1'b0;
    @(negedge HCLK);
    chk("mid_hwdata", 0, HWDATA, 32'hCAFEF00D);
    chk("mid_count",  0, 32'(xfer_count), 32'd9);
    HRESETn = 1'b0;
    #1 check_reset(1);
    HREADY = 1'b1;
    @(posedge HCLK);
    @(posedge HCLK);
    @(negedge HCLK);
    check_reset(2);
    HRESETn = 1'b1;
    #1 chk("ready_after_release", 0, 32'(cmd_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      chk("post_rst_rsp_valid", i, 32'(rsp_valid), 32'h0);
      chk("post_rst_ready",     i, 32'(cmd_ready), 32'h1);
    end

    // counter wrap: 65535 streamed writes, then one more
    acc = 0;
    for (int i = 0; i < 65535; i++) begin
      @(posedge HCLK);
      #1 begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'(i) << 2; cmd_wdata = 32'(i);
      end
      @(negedge HCLK);
      if (cmd_ready) acc++;
    end
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("stream_accepts", 0, 32'(acc),        32'd65535);
    chk("count_ffff",     0, 32'(xfer_count), 32'h0000FFFF);
    @(posedge HCLK);
    #1 cmd_valid = 1'b1;
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("count_wrap", 0, 32'(xfer_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
